lane_deskew_fifo: RTL and testbench
===================================

# lane_deskew_fifo

Per-lane programmable-delay buffer in the PCS receive path, one instance per PCS lane, placed directly downstream of the deskew FSM. Once the FSM asserts its set-FIFO-delay strobe, the block latches that lane's skew as `common_counter − lane_counter` and then re-emits the lane's 66-bit block stream delayed by that many valid blocks. All 20 lanes are therefore aligned at the reorder/decode stage. It also reports an unusable skew value and exposes its current delay for debug.

## Interface
Parameters:
- `NB_DATA`, 66: block width (sync header + payload).
- `MAX_SKEW`, 16: buffer depth in blocks; must be a power of two.
- `NB_PTR`, `$clog2(MAX_SKEW)`: pointer width.
- `NB_COUNT`, `$clog2(MAX_SKEW)+1`: skew-counter width; can hold the value `MAX_SKEW`.

Ports (one clock; reset is asynchronous and active-low):
- `i_clock`, in, 1: system clock.
- `i_reset_n`, in, 1: asynchronous active-low reset.
- `i_enable`, in, 1: global clock enable; when low, all state is frozen.
- `i_valid`, in, 1: `i_data` carries a block this cycle.
- `i_data`, in, NB_DATA: lane block.
- `i_resync`, in, 1: discard the programmed delay (same strobe that feeds the deskew FSM).
- `i_set_fifo_delay`, in, 1: one-cycle strobe from the deskew FSM.
- `i_common_counter`, in, NB_COUNT: common skew counter value.
- `i_lane_counter`, in, NB_COUNT: this lane's stopped counter value.
- `o_valid`, out, 1: `o_data` is a deskewed block.
- `o_data`, out, NB_DATA: delayed block.
- `o_locked`, out, 1: a valid delay is programmed.
- `o_delay_error`, out, 1: the last set attempt was rejected (sticky).
- `o_delay`, out, NB_PTR: current delay value.

## Operation
- Storage is a circular RAM of MAX_SKEW entries. A write happens on every cycle with `i_enable & i_valid`, and writes continue in every state. `wr_ptr` increments modulo MAX_SKEW and wraps naturally.
- `fill` is a saturating count of writes since reset or resync. It caps at MAX_SKEW−1.
- Delay computation happens when `i_set_fifo_delay & i_enable`:
  - `d = i_common_counter − i_lane_counter`, computed NB_COUNT bits wide.
  - The set is rejected if `i_lane_counter > i_common_counter`, if `d ≥ MAX_SKEW`, or if `d > fill`.
  - On rejection: set `o_delay_error`, leave `delay` and `o_locked` unchanged.
  - Otherwise: load `delay = d`, set `o_locked`, clear `o_delay_error`.
- States:
  - UNLOCKED: `o_valid` is held at 0; the buffer still fills. A good set moves the block to LOCKED.
  - LOCKED: for each input valid block, `o_valid` = 1 on the next cycle. `o_data` = the block written `delay` valid-writes earlier. When `delay` = 0, it is the current input block.
- A good set while LOCKED (re-program) takes effect on the next valid read. `o_valid` does not drop, so blocks may be repeated or skipped at the switchover. This is acceptable because the upstream lock is being re-established.
- `i_resync` (with `i_enable`) moves the block to UNLOCKED and clears `fill`, `delay`, and `o_delay_error`. If `i_resync` and `i_set_fifo_delay` arrive in the same cycle, resync wins.

## Timing
- Reset values: `o_valid` = 0, `o_data` = 0, `o_locked` = 0, `o_delay_error` = 0, `o_delay` = 0; also `wr_ptr` = 0, `fill` = 0.
- Latency is 1 clock from `i_valid` to `o_valid`. This registered output is in addition to the programmed delay of `delay` valid blocks.
- The read address is `wr_ptr − delay` modulo MAX_SKEW, evaluated in the same cycle as the write. The `delay` = 0 case bypasses the RAM to take `i_data`.
- The delay is loaded on the clock edge where the strobe is sampled. `o_locked` rises on that edge, so the first deskewed `o_valid` appears at the earliest on the following cycle.
- If `i_enable` is low, nothing advances, including `o_valid`, which holds its value.
- An asynchronous reset in mid-stream immediately zeroes every output. The RAM contents are not reset.

## Structure
- Shared package `pcs_deskew_pkg` holds:
  - the constants `NB_BLOCK` = 66, `MAX_SKEW` = 16, `N_LANES` = 20;
  - the UNLOCKED/LOCKED state encoding;
  - the skew-width function, shared with the deskew FSM so the counter widths match.
- One natural sub-module: `deskew_ram`, a simple dual-port RAM with a synchronous write and an asynchronous read, parameterised by depth and width. The pointer, fill, and delay logic live in the top module.

## Test plan
- **Basic delay:** set with common = 9, lane = 4 after 10 writes, then stream blocks 0,1,2,… → `o_delay` = 5, `o_locked` = 1. The output on the cycle after input block N is block N−5.
- **Zero delay:** common = lane = 7 → `o_data` equals the previous cycle's `i_data`, with no gap in `o_valid`.
- **Rejections:**
  - lane = 8, common = 3 → `o_delay_error` = 1, `o_locked` stays 0, `o_valid` stays 0.
  - common = 16, lane = 0 → same response.
  - d = 6 with only 3 writes done → same response.
- **Resync priority:** `i_resync` and `i_set_fifo_delay` (d = 2) in the same cycle → UNLOCKED, `o_delay` = 0, `fill` = 0.
- **Wrap and gaps:** 40 blocks with `i_valid` toggling at 50% and delay 15 → the output sequence is exactly the input sequence shifted by 15 valid blocks across pointer wraps. `o_valid` pulses only on cycles following an input valid.
- **Async reset mid-stream:** assert `i_reset_n` low between clock edges → all outputs are 0 immediately. After release, a new set with d = 3 relocks correctly.

Source files
------------

// File: rtl/pcs_deskew_pkg.sv
// Shared PCS deskew constants, lock-state encoding and skew-width helper.
// Used by the deskew FSM and the per-lane deskew FIFOs.
package pcs_deskew_pkg;

  localparam int NB_BLOCK = 66;
  localparam int MAX_SKEW = 16;
  localparam int N_LANES  = 20;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Counter width able to hold the value max_skew itself.
  function automatic int skew_width(input int max_skew);
    return $clog2(max_skew) + 1;
  endfunction

endpackage

// File: rtl/deskew_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read.
// Ports: i_clock, i_wr_en/i_wr_addr/i_wr_data write side, i_rd_addr -> o_rd_data.
module deskew_ram #(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 66,
  parameter int NB_ADDR = $clog2(DEPTH)
) (
  input  logic               i_clock,
  input  logic               i_wr_en,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]   i_wr_data,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [WIDTH-1:0]   o_rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/lane_deskew_fifo.sv
// Per-lane programmable-delay buffer: re-emits the lane block stream delayed
// by (common - lane) valid blocks. Ports: i_* stream/strobes in, o_* stream/status out.
module lane_deskew_fifo
  import pcs_deskew_pkg::*;
#(
  parameter int NB_DATA  = pcs_deskew_pkg::NB_BLOCK,
  parameter int MAX_SKEW = pcs_deskew_pkg::MAX_SKEW,
  parameter int NB_PTR   = $clog2(MAX_SKEW),
  parameter int NB_COUNT = skew_width(MAX_SKEW)
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_enable,
  input  logic                i_valid,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic                i_resync,
  input  logic                i_set_fifo_delay,
  input  logic [NB_COUNT-1:0] i_common_counter,
  input  logic [NB_COUNT-1:0] i_lane_counter,
  output logic                o_valid,
  output logic [NB_DATA-1:0]  o_data,
  output logic                o_locked,
  output logic                o_delay_error,
  output logic [NB_PTR-1:0]   o_delay
);

  localparam logic [NB_PTR-1:0] FILL_MAX = NB_PTR'(MAX_SKEW - 1);

  logic [NB_PTR-1:0]   wr_ptr_q, wr_ptr_d;
  logic [NB_PTR-1:0]   fill_q, fill_d;
  logic [NB_PTR-1:0]   delay_q, delay_d;
  lock_state_e         state_q, state_d;
  logic                err_q, err_d;
  logic                valid_q, valid_d;
  logic [NB_DATA-1:0]  data_q, data_d;

  logic                wr_en;
  logic [NB_PTR-1:0]   rd_addr;
  logic [NB_DATA-1:0]  rd_data;
  logic [NB_COUNT-1:0] diff;
  logic                set_ok;

  assign wr_en   = i_enable & i_valid;
  // Entry written `delay` valid-writes ago; wraps modulo depth.
  assign rd_addr = wr_ptr_q - delay_q;
  assign diff    = i_common_counter - i_lane_counter;
  assign set_ok  = (i_lane_counter <= i_common_counter)
                 && (diff < NB_COUNT'(MAX_SKEW))
                 && (diff <= NB_COUNT'(fill_q));

  deskew_ram #(
    .DEPTH (MAX_SKEW),
    .WIDTH (NB_DATA)
  ) u_ram (
    .i_clock   (i_clock),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (i_data),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    delay_d  = delay_q;
    state_d  = state_q;
    err_d    = err_q;
    valid_d  = valid_q;
    data_d   = data_q;
    if (i_enable) begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + NB_PTR'(1);
        if (fill_q != FILL_MAX) begin
          fill_d = fill_q + NB_PTR'(1);
        end
      end
      valid_d = wr_en && (state_q == LOCKED);
      if (valid_d) begin
        // Zero delay must bypass: the RAM slot is written this same edge.
        data_d = (delay_q == '0) ? i_data : rd_data;
      end
      if (i_resync) begin
        state_d = UNLOCKED;
        fill_d  = '0;
        delay_d = '0;
        err_d   = 1'b0;
        valid_d = 1'b0;
      end else if (i_set_fifo_delay) begin
        if (set_ok) begin
          delay_d = diff[NB_PTR-1:0];
          state_d = LOCKED;
          err_d   = 1'b0;
        end else begin
          err_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      delay_q  <= '0;
      state_q  <= UNLOCKED;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      delay_q  <= delay_d;
      state_q  <= state_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_data        = data_q;
  assign o_locked      = (state_q == LOCKED);
  assign o_delay_error = err_q;
  assign o_delay       = delay_q;

endmodule

// File: tb/tb_lane_deskew_fifo.sv
// Scoreboard bench for lane_deskew_fifo: directed stimulus pushes expected
// blocks, a negedge monitor pops and compares whenever o_valid is presented.
module tb_lane_deskew_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        valid = 1'b0;
  logic        resync = 1'b0;
  logic        setd = 1'b0;
  logic [65:0] data = '0;
  logic [4:0]  common = '0;
  logic [4:0]  lane = '0;

  logic        o_valid;
  logic [65:0] o_data;
  logic        o_locked;
  logic        o_err;
  logic [3:0]  o_delay;

  int          checks = 0;
  int          errors = 0;
  logic [65:0] exp_q [$];
  int          n = 0;
  bit          exp_locked = 0;
  int          exp_dly = 0;
  logic        prev_en = 1'b0;
  logic        prev_v = 1'b0;

  lane_deskew_fifo dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .i_enable         (en),
    .i_valid          (valid),
    .i_data           (data),
    .i_resync         (resync),
    .i_set_fifo_delay (setd),
    .i_common_counter (common),
    .i_lane_counter   (lane),
    .o_valid          (o_valid),
    .o_data           (o_data),
    .o_locked         (o_locked),
    .o_delay_error    (o_err),
    .o_delay          (o_delay)
  );

  always #5 clk = ~clk;

  function automatic logic [65:0] blk(input int k);
    return {2'b01, 32'hC0DE_0000, 32'(k)};
  endfunction

  task automatic check(input string nm, input logic [65:0] act,
                       input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle of stimulus; returns 1 time unit after the edge.
  task automatic drive(input bit v, input bit e = 1, input bit rs = 0,
                       input bit st = 0, input logic [4:0] c = 0,
                       input logic [4:0] l = 0);
    valid  = v;
    en     = e;
    resync = rs;
    setd   = st;
    common = c;
    lane   = l;
    data   = v ? blk(n) : '0;
    if (e && v) begin
      if (exp_locked) exp_q.push_back(blk(n - exp_dly));
      n++;
    end
    @(posedge clk);
    #1;
    valid  = 1'b0;
    en     = 1'b1;
    resync = 1'b0;
    setd   = 1'b0;
    data   = '0;
  endtask

  task automatic stream(input int k);
    repeat (k) drive(1);
  endtask

  task automatic check_status(input string nm, input logic lk,
                              input logic er, input logic [3:0] dl);
    check({nm, "_locked"}, o_locked, lk);
    check({nm, "_err"}, o_err, er);
    check({nm, "_delay"}, o_delay, dl);
  endtask

  always @(posedge clk) begin
    prev_en <= en;
    prev_v  <= valid;
  end

  always @(negedge clk) begin
    if (rst_n && prev_en && o_valid) begin
      check("valid_after_input", prev_v, 1'b1);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got data %0h expected no output", o_data);
      end else begin
        logic [65:0] e;
        e = exp_q.pop_front();
        if (o_data !== e) begin
          errors++;
          $display("FAIL out_data: got %0h expected %0h", o_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_data", o_data, '0);
    check_status("rst", 1'b0, 1'b0, 4'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic delay of 5 after 10 writes
    repeat (10) drive(1);
    drive(0, 1, 0, 1, 5'd9, 5'd4);
    check_status("basic", 1'b1, 1'b0, 4'd5);
    check("basic_valid_idle", o_valid, 1'b0);
    exp_locked = 1;
    exp_dly = 5;
    stream(12);

    // Re-program to zero delay: output tracks the previous input
    drive(0, 1, 0, 1, 5'd7, 5'd7);
    check_status("zero", 1'b1, 1'b0, 4'd0);
    exp_dly = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1);
      check("zero_valid", o_valid, 1'b1);
    end

    // Rejection: lane > common
    drive(0, 1, 1);
    check_status("resync1", 1'b0, 1'b0, 4'd0);
    exp_locked = 0;
    exp_dly = 0;
    repeat (3) drive(1);
    drive(0, 1, 0, 1, 5'd3, 5'd8);
    check_status("rej_lane_gt", 1'b0, 1'b1, 4'd0);

    // Rejection: d = MAX_SKEW
    drive(0, 1, 1);
    check("resync_clears_err", o_err, 1'b0);
    repeat (3) drive(1);
    drive(0, 1, 0, 1, 5'd16, 5'd0);
    check_status("rej_max", 1'b0, 1'b1, 4'd0);

    // Rejection: d exceeds fill
    drive(0, 1, 1);
    repeat (3) drive(1);
    drive(0, 1, 0, 1, 5'd6, 5'd0);
    check_status("rej_fill", 1'b0, 1'b1, 4'd0);
    stream(2);
    check("rej_no_valid", o_valid, 1'b0);

    // Good set (fill is 5), then resync + set in the same cycle
    drive(0, 1, 0, 1, 5'd5, 5'd3);
    check_status("set_d2", 1'b1, 1'b0, 4'd2);
    exp_locked = 1;
    exp_dly = 2;
    stream(3);
    drive(0, 1, 1, 1, 5'd5, 5'd3);
    check_status("resync_prio", 1'b0, 1'b0, 4'd0);
    exp_locked = 0;
    exp_dly = 0;
    // fill was cleared, so even d = 1 must be rejected
    drive(0, 1, 0, 1, 5'd1, 5'd0);
    check_status("fill_cleared", 1'b0, 1'b1, 4'd0);

    // Delay 15 with 50% valid, across pointer wraps
    drive(0, 1, 1);
    repeat (16) drive(1);
    drive(0, 1, 0, 1, 5'd15, 5'd0);
    check_status("set_d15", 1'b1, 1'b0, 4'd15);
    exp_locked = 1;
    exp_dly = 15;
    for (int i = 0; i < 80; i++) drive(i % 2 == 0);

    // Enable low freezes everything, including o_valid/o_data
    stream(2);
    drive(1, 0);
    drive(1, 0);
    check("freeze_valid", o_valid, 1'b1);
    check("freeze_data", o_data, blk(n - 1 - 15));
    stream(3);

    // Asynchronous reset between edges
    drive(1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", o_valid, 1'b0);
    check("arst_data", o_data, '0);
    check_status("arst", 1'b0, 1'b0, 4'd0);
    exp_locked = 0;
    exp_dly = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) drive(1);
    drive(0, 1, 0, 1, 5'd3, 5'd0);
    check_status("relock", 1'b1, 1'b0, 4'd3);
    exp_locked = 1;
    exp_dly = 3;
    stream(6);
    drive(0);
    drive(0);
    check("scoreboard_drained", 66'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
